// File: rtl/alu_wide_seq.sv
// alu_wide_seq
//   Runs W-bit (W = 8*BYTES) operations on an external combinational 8-bit ALU,
//   one byte per clock. It latches the operands at start, presents one byte
//   pair per cycle through registered ALU drive lines, chains carry between
//   bytes, and captures each result byte. At the end it assembles the wide
//   result and the combined flags.
//
//   Timeline (start sampled at edge 0):
//     edge 0          IDLE -> RUN, operands latched
//     edges 1..BYTES  byte k is issued on the ALU lines (alu_oe=0); from edge 2
//                     on, the byte issued one cycle earlier is captured
//     edge BYTES+1    last byte captured, flags finalised, done raised
//     edge BYTES+2    done falls, back to IDLE
//
// Ports
//   clk, rst            clock (rising edge); asynchronous active-high reset
//   start               operation request, sampled only in IDLE
//   op, invert          ALU opcode / invert control, latched at start
//   carry_in            carry into the first processed byte, latched at start
//   chain               1: byte k>0 takes the carry of the previous byte
//   dir                 0: LSB byte first, 1: MSB byte first
//   a_in, b_in          wide operands, latched at start
//   alu_a, alu_b        byte operands to the ALU
//   alu_op, alu_invert  opcode / invert to the ALU
//   alu_carry_in        carry to the ALU
//   alu_oe              ALU output enable (0 = ALU drives the bus)
//   alu_result          ALU result bus
//   alu_flags           ALU flags {overflow, sign, carry, zero}
//   busy                high while an operation is in flight
//   done                one-cycle completion pulse
//   result              assembled wide result, held until the next start
//   flags               combined flags {overflow, sign, carry, zero}
module alu_wide_seq #(
   parameter int BYTES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           op,
   input  logic                 invert,
   input  logic                 carry_in,
   input  logic                 chain,
   input  logic                 dir,
   input  logic [8*BYTES-1:0]   a_in,
   input  logic [8*BYTES-1:0]   b_in,
   output logic [7:0]           alu_a,
   output logic [7:0]           alu_b,
   output logic [3:0]           alu_op,
   output logic                 alu_invert,
   output logic                 alu_carry_in,
   output logic                 alu_oe,
   input  logic [7:0]           alu_result,
   input  logic [3:0]           alu_flags,
   output logic                 busy,
   output logic                 done,
   output logic [8*BYTES-1:0]   result,
   output logic [3:0]           flags
);

   localparam int W  = 8 * BYTES;
   localparam int IW = $clog2(BYTES + 1);
   localparam logic [IW-1:0] LAST = IW'(BYTES);
   localparam logic [IW-1:0] TOP  = IW'(BYTES - 1);
   localparam logic [IW-1:0] ONE  = IW'(1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state, state_nxt;

   // Operation latched at start
   logic [W-1:0]  a_lat, b_lat;
   logic [3:0]    op_lat;
   logic          inv_lat, cin_lat, chain_lat, dir_lat;

   // idx counts issued bytes; byte idx-1 is the one on the ALU this cycle
   logic [IW-1:0] idx;
   logic          zacc;
   logic          sign_top, ovf_top;

   logic [IW-1:0] drv_p, cap_p;
   logic [7:0]    a_byte, b_byte;
   logic          top_cap;

   // Map processing order to physical byte position
   function automatic logic [IW-1:0] phys(input logic [IW-1:0] i, input logic d);
      return d ? (TOP - i) : i;
   endfunction

   always_comb begin
      drv_p   = phys(idx, dir_lat);
      cap_p   = phys(idx - ONE, dir_lat);
      top_cap = (cap_p == TOP);
      a_byte  = '0;
      b_byte  = '0;
      for (int k = 0; k < BYTES; k++) begin
         if (drv_p == IW'(k)) begin
            a_byte = a_lat[8*k +: 8];
            b_byte = b_lat[8*k +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (idx == LAST) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         alu_oe       <= 1'b1;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         alu_invert   <= 1'b0;
         alu_carry_in <= 1'b0;
         result       <= '0;
         flags        <= '0;
         a_lat        <= '0;
         b_lat        <= '0;
         op_lat       <= '0;
         inv_lat      <= 1'b0;
         cin_lat      <= 1'b0;
         chain_lat    <= 1'b0;
         dir_lat      <= 1'b0;
         zacc         <= 1'b1;
         sign_top     <= 1'b0;
         ovf_top      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               busy   <= 1'b0;
               done   <= 1'b0;
               alu_oe <= 1'b1;
               if (start) begin
                  a_lat     <= a_in;
                  b_lat     <= b_in;
                  op_lat    <= op;
                  inv_lat   <= invert;
                  cin_lat   <= carry_in;
                  chain_lat <= chain;
                  dir_lat   <= dir;
                  idx       <= '0;
                  zacc      <= 1'b1;
               end
            end
            RUN: begin
               busy <= 1'b1;
               // -- capture stage: byte issued last cycle is on alu_result now
               if (idx != '0) begin
                  for (int k = 0; k < BYTES; k++) begin
                     if (cap_p == IW'(k)) result[8*k +: 8] <= alu_result;
                  end
                  zacc <= zacc & alu_flags[0];
                  if (top_cap) begin
                     sign_top <= alu_flags[2];
                     ovf_top  <= alu_flags[3];
                  end
               end
               // -- issue stage: next byte pair onto the ALU lines
               if (idx != LAST) begin
                  alu_a      <= a_byte;
                  alu_b      <= b_byte;
                  alu_op     <= op_lat;
                  alu_invert <= inv_lat;
                  alu_oe     <= 1'b0;
                  // The carry of the byte being captured feeds the next one directly
                  alu_carry_in <= (idx == '0 || !chain_lat) ? cin_lat : alu_flags[1];
                  idx <= idx + ONE;
               end else begin
                  alu_oe <= 1'b1;
                  done   <= 1'b1;
                  flags  <= {top_cap ? alu_flags[3] : ovf_top,
                             top_cap ? alu_flags[2] : sign_top,
                             alu_flags[1],
                             zacc & alu_flags[0]};
               end
            end
            DONE: begin
               busy   <= 1'b0;
               done   <= 1'b0;
               alu_oe <= 1'b1;
            end
            default: begin
               busy   <= 1'b0;
               done   <= 1'b0;
               alu_oe <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Testbench for alu_wide_seq with a behavioural 8-bit ALU attached.
module tb_alu_wide_seq;

   localparam int BYTES = 2;
   localparam int W     = 8 * BYTES;
   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_AND = 4'h1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [3:0]    op = '0;
   logic          invert = 1'b0, carry_in = 1'b0, chain = 1'b0, dir = 1'b0;
   logic [W-1:0]  a_in = '0, b_in = '0;
   logic [7:0]    alu_a, alu_b, alu_result;
   logic [3:0]    alu_op, alu_flags;
   logic          alu_invert, alu_carry_in, alu_oe;
   logic          busy, done;
   logic [W-1:0]  result;
   logic [3:0]    flags;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_wide_seq #(.BYTES(BYTES)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .invert(invert),
      .carry_in(carry_in), .chain(chain), .dir(dir), .a_in(a_in), .b_in(b_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_invert(alu_invert),
      .alu_carry_in(alu_carry_in), .alu_oe(alu_oe), .alu_result(alu_result),
      .alu_flags(alu_flags), .busy(busy), .done(done), .result(result), .flags(flags)
   );

   // 8-bit ALU: returns {overflow, sign, carry, zero, result[7:0]}
   function automatic logic [11:0] alu8(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] o, input logic inv, input logic cin);
      logic [7:0] bb, r;
      logic [8:0] s;
      logic       c, v;
      bb = inv ? ~b : b;
      if (o == OP_ADD) begin
         s = {1'b0, a} + {1'b0, bb} + {8'd0, cin};
         r = s[7:0];
         c = s[8];
         v = (a[7] == bb[7]) && (r[7] != a[7]);
      end else begin
         r = a & bb;
         c = 1'b0;
         v = 1'b0;
      end
      return {v, r[7], c, (r == 8'h00), r};
   endfunction

   // Combinational ALU; the bus value while alu_oe=1 is never captured
   assign {alu_flags, alu_result} = alu8(alu_a, alu_b, alu_op, alu_invert, alu_carry_in);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int           mk = -1;           // cycles since the start edge, -1 when idle
   logic [7:0]   ea [BYTES];
   logic [7:0]   eb [BYTES];
   logic         ec [BYTES];
   logic [3:0]   eop;
   logic         einv;
   logic [W-1:0] eres, held_res;
   logic [3:0]   eflg, held_flg;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mk       <= -1;
         held_res <= '0;
         held_flg <= '0;
      end else if (mk < 0) begin
         if (start) begin
            logic [7:0]   ta [BYTES];
            logic [7:0]   tb [BYTES];
            logic         tc [BYTES];
            logic [W-1:0] r;
            logic [11:0]  o12;
            logic         cy, ovf;
            int           p;
            r   = '0;
            cy  = 1'b0;
            ovf = 1'b0;
            for (int i = 0; i < BYTES; i++) begin
               p     = dir ? BYTES - 1 - i : i;
               ta[i] = a_in[8*p +: 8];
               tb[i] = b_in[8*p +: 8];
               tc[i] = (i == 0 || !chain) ? carry_in : cy;
               o12   = alu8(ta[i], tb[i], op, invert, tc[i]);
               r[8*p +: 8] = o12[7:0];
               cy    = o12[9];
               if (p == BYTES - 1) ovf = o12[11];
            end
            ea   <= ta;
            eb   <= tb;
            ec   <= tc;
            eop  <= op;
            einv <= invert;
            eres <= r;
            eflg <= {ovf, r[W-1], cy, (r == '0)};
            mk   <= 0;
         end
      end else begin
         if (mk + 1 == BYTES + 1) begin
            held_res <= eres;
            held_flg <= eflg;
         end
         mk <= (mk + 1 == BYTES + 2) ? -1 : mk + 1;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("busy", busy, (mk >= 1 && mk <= BYTES + 1));
         chk("done", done, (mk == BYTES + 1));
         chk("alu_oe", alu_oe, !(mk >= 1 && mk <= BYTES));
         if (mk >= 1 && mk <= BYTES) begin
            chk("alu_a", alu_a, ea[mk-1]);
            chk("alu_b", alu_b, eb[mk-1]);
            chk("alu_op", alu_op, eop);
            chk("alu_invert", alu_invert, einv);
            chk("alu_carry_in", alu_carry_in, ec[mk-1]);
         end
         if (mk <= 1 || mk == BYTES + 1) begin
            chk("result", result, held_res);
            chk("flags", flags, held_flg);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] o,
                         input logic inv, input logic cin, input logic ch, input logic d,
                         input bit pulse_again,
                         output int lat, output int nd, output int noe,
                         output logic [7:0] s0, output logic [7:0] s1);
      @(negedge clk);
      a_in = a; b_in = b; op = o; invert = inv; carry_in = cin; chain = ch; dir = d;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; nd = 0; noe = 0; s0 = '0; s1 = '0;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1;
         if (c == 1) s0 = alu_a;
         if (c == 2) s1 = alu_a;
         if (!alu_oe) noe++;
         if (done) begin
            nd++;
            if (lat == 0) lat = c;
         end
         if (pulse_again && c == 1) begin
            start = 1'b1;
            a_in  = ~a;
            b_in  = ~b;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   initial begin
      int lat, nd, noe;
      logic [7:0] s0, s1;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_oe", alu_oe, 1);
      chk("rst_result", result, 0);
      chk("rst_flags", flags, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_cin", alu_carry_in, 0);
      @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Carry ripples from low byte into high byte
      run_op(16'h00FF, 16'h0001, OP_ADD, 0, 0, 1, 0, 0, lat, nd, noe, s0, s1);
      chk("t1_latency", lat, 3);
      chk("t1_ndone", nd, 1);
      chk("t1_result", result, 16'h0100);
      chk("t1_flags", flags, 4'b0000);

      // Wrap to zero with carry out
      run_op(16'hFFFF, 16'h0001, OP_ADD, 0, 0, 1, 0, 0, lat, nd, noe, s0, s1);
      chk("t2_result", result, 16'h0000);
      chk("t2_flags", flags, 4'b0011);

      // Signed overflow into the sign bit
      run_op(16'h7FFF, 16'h0001, OP_ADD, 0, 0, 1, 0, 0, lat, nd, noe, s0, s1);
      chk("t3_result", result, 16'h8000);
      chk("t3_flags", flags, 4'b1100);

      // MSB-first byte order
      run_op(16'h1234, 16'h0101, OP_ADD, 0, 0, 1, 1, 0, lat, nd, noe, s0, s1);
      chk("t4_alu_a_run0", s0, 8'h12);
      chk("t4_alu_a_run1", s1, 8'h34);
      chk("t4_oe_cycles", noe, 2);
      chk("t4_result", result, 16'h1335);

      // MSB-first with chaining: low byte's carry is the last processed carry
      run_op(16'h01FF, 16'h0001, OP_ADD, 0, 0, 1, 1, 0, lat, nd, noe, s0, s1);
      chk("t5_result", result, 16'h0100);
      chk("t5_flags", flags, 4'b0010);

      // Second start during RUN is ignored, chain=0 drops the carry
      run_op(16'h00FF, 16'h0001, OP_ADD, 0, 0, 0, 0, 1, lat, nd, noe, s0, s1);
      chk("t6_ndone", nd, 1);
      chk("t6_result", result, 16'h0000);
      chk("t6_flags", flags, 4'b0001);

      // Non-add opcode with invert
      run_op(16'hF0F0, 16'h00FF, OP_AND, 1, 0, 0, 0, 0, lat, nd, noe, s0, s1);
      chk("t7_result", result, 16'hF000);
      chk("t7_flags", flags, 4'b0100);

      // Reset during RUN cycle 1
      @(negedge clk);
      a_in = 16'h0102; b_in = 16'h0304; op = OP_ADD; invert = 0;
      carry_in = 0; chain = 1; dir = 0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("t8_busy", busy, 0);
      chk("t8_oe", alu_oe, 1);
      chk("t8_result", result, 0);
      chk("t8_flags", flags, 0);
      chk("t8_done", done, 0);
      nd = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (done) nd++;
      end
      @(negedge clk);
      rst = 1'b0;
      chk("t8_no_done", nd, 0);

      run_op(16'h0102, 16'h0304, OP_ADD, 0, 0, 1, 0, 0, lat, nd, noe, s0, s1);
      chk("t9_latency", lat, 3);
      chk("t9_result", result, 16'h0406);
      chk("t9_flags", flags, 4'b0000);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
Multi-byte operation sequencer that drives the 8-bit ALU across its operand/opcode/oe interface, one byte per clock. It latches wide operands, presents one byte pair per cycle, chains carry between bytes, and captures the ALU result and flags. It assembles the wide result and combined flags for the control unit, so 16-bit (or wider) arithmetic runs on the existing ALU without extra datapath.

Parameters:
BYTES, 2, operand width in bytes (≥2); wide width W = 8*BYTES.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
op  in  4  ALU opcode (gen-alu.py encoding), latched at start.
invert  in  1  ALU invert control, latched at start.
carry_in  in  1  carry into first processed byte, latched at start.
chain  in  1  1 = byte k>0 takes carry from previous byte's flags[1]; 0 = every byte takes carry_in. Latched at start.
dir  in  1  0 = LSB byte first, 1 = MSB byte first. Latched at start.
a_in  in  W  operand A.
b_in  in  W  operand B.
alu_a  out  8  byte to ALU a.
alu_b  out  8  byte to ALU b.
alu_op  out  4  to ALU op.
alu_invert  out  1  to ALU invert.
alu_carry_in  out  1  to ALU carry_in.
alu_oe  out  1  to ALU oe; 1 = ALU result hi-Z, 0 = ALU drives the bus.
alu_result  in  8  ALU result bus.
alu_flags  in  4  ALU flags {overflow, sign, carry, zero}.
busy  out  1  high from the cycle after start until done.
done  out  1  one-cycle completion pulse.
result  out  W  assembled result; held until next start.
flags  out  4  combined flags {overflow, sign, carry, zero}; held until next start.

Behaviour:
- Reset (async, any state): state=IDLE, byte index=0, busy=0, done=0, alu_oe=1, alu_a=alu_b=0, alu_op=0, alu_invert=0, alu_carry_in=0, result=0, flags=0.
- States: IDLE, RUN, DONE.
- IDLE: alu_oe=1. If start=1, latch all inputs, set index=0, clear zero accumulator to 1, go to RUN. result/flags unchanged until the first RUN capture.
- RUN: exactly BYTES cycles. Physical byte p = index when dir=0, p = BYTES-1-index when dir=1. Drive alu_a=A[8p+7:8p], alu_b=B[8p+7:8p], alu_oe=0, alu_op/alu_invert from the latch.
- alu_carry_in: the latched carry_in when index=0 or chain=0; otherwise the carry captured in the previous RUN cycle.
- ALU is combinational. At each RUN clock edge, capture alu_result into result[8p+7:8p]. Set the zero accumulator to accumulator AND alu_flags[0]. Store alu_flags[1] as the chain carry. If p=BYTES-1, capture alu_flags[2] and alu_flags[3].
- After the last RUN cycle: flags[0]=zero accumulator (all bytes zero). flags[1]=carry of the last processed byte. flags[2]=captured sign of the top byte. flags[3]=captured overflow of the top byte. Then go to DONE.
- DONE: done=1 for one cycle, alu_oe=1, then IDLE.
- Latency: start sampled at edge 0. RUN covers edges 1..BYTES. done is high during the cycle after edge BYTES+1 and falls at edge BYTES+2. busy=1 from edge 1 through the end of DONE.
- start while in RUN or DONE is ignored; it is not queued.
- Inputs changing during RUN have no effect, because operands are latched.
- Reset mid-operation aborts immediately to the reset values; no partial result is retained.
- alu_oe is never 0 outside RUN, so the bus is free for other drivers.

Test Plan:
- Bench connects the real ALU; op=ADD. a_in=0x00FF, b_in=0x0001, chain=1, carry_in=0, dir=0 -> result=0x0100, flags zero=0, carry=0. done pulses exactly 3 cycles after start.
- ADD 0xFFFF + 0x0001, chain=1 -> result=0x0000, zero=1, carry=1, sign=0.
- ADD 0x7FFF + 0x0001, chain=1 -> result=0x8000, sign=1, overflow=1, zero=0.
- a_in=0x1234, dir=1 -> alu_a shows 0x12 in RUN cycle 0 and 0x34 in RUN cycle 1. alu_oe=0 only in those two cycles.
- Pulse start again during RUN -> ignored: exactly one done pulse, result from the first operands. ADD 0x00FF + 0x0001 with chain=0 -> result=0x0000, carry=0.
- Assert rst in RUN cycle 1 -> same cycle: busy=0, alu_oe=1, result=0, flags=0, no done. A new start then completes normally.
